// File: rtl/tdm_demux.sv
// tdm_demux: steers a framed TDM sample stream into registered per-channel slots and flags alignment loss.
// Optional saturating error counter on err_count when TDM_DEMUX_ERRCNT_EN is defined.
module tdm_demux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    localparam int CW      = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          in_data,
    input  logic                      in_valid,
    input  logic                      in_frame,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       out_strobe,
    output logic                      frame_done,
    output logic                      sync_err
`ifdef TDM_DEMUX_ERRCNT_EN
    ,
    output logic [7:0]                err_count
`endif
);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             ch_idx_q, ch_idx_d;
    logic [CHANNELS*WIDTH-1:0] data_q, data_d;
    logic [CHANNELS-1:0]       strobe_q, strobe_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic                      last_ch;

    assign last_ch = (ch_idx_q == CW'(CHANNELS - 1));

    always_comb begin
        state_d  = state_q;
        ch_idx_d = ch_idx_q;
        data_d   = data_q;
        strobe_d = '0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        if (in_valid) begin
            if (state_q == HUNT) begin
                if (in_frame) begin
                    data_d[WIDTH-1:0] = in_data;
                    strobe_d[0]       = 1'b1;
                    ch_idx_d          = CW'(1);
                    state_d           = LOCKED;
                end
            end else if (in_frame) begin
                // A marker always realigns; it is an error only if it arrives early.
                err_d             = (ch_idx_q != '0);
                data_d[WIDTH-1:0] = in_data;
                strobe_d[0]       = 1'b1;
                ch_idx_d          = CW'(1);
            end else if (ch_idx_q == '0) begin
                err_d   = 1'b1;
                state_d = HUNT;
            end else begin
                data_d[ch_idx_q*WIDTH +: WIDTH] = in_data;
                strobe_d[ch_idx_q]              = 1'b1;
                done_d                          = last_ch;
                ch_idx_d                        = last_ch ? '0 : CW'(ch_idx_q + 1'b1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= HUNT;
            ch_idx_q <= '0;
            data_q   <= '0;
            strobe_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_idx_q <= ch_idx_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign out_data   = data_q;
    assign out_strobe = strobe_q;
    assign frame_done = done_q;
    assign sync_err   = err_q;

`ifdef TDM_DEMUX_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_cnt_q <= '0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed checks of tdm_demux framing, slot steering, error pulses and async reset.
module tb_tdm_demux;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_frame = 1'b0;
    logic [31:0] out_data;
    logic [3:0]  out_strobe;
    logic        frame_done;
    logic        sync_err;
`ifdef TDM_DEMUX_ERRCNT_EN
    logic [7:0]  err_count;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tdm_demux #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_frame   (in_frame),
        .out_data   (out_data),
        .out_strobe (out_strobe),
        .frame_done (frame_done),
        .sync_err   (sync_err)
`ifdef TDM_DEMUX_ERRCNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one input beat for one clock, then leaves outputs settled for checking.
    task automatic send(input logic v, input logic f, input logic [7:0] d);
        in_valid = v;
        in_frame = f;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_frame = 1'b0;
    endtask

    task automatic pulses(input string tag, input logic [3:0] s, input logic fd, input logic se);
        check({tag, ".strobe"}, 32'(out_strobe), 32'(s));
        check({tag, ".done"}, 32'(frame_done), 32'(fd));
        check({tag, ".err"}, 32'(sync_err), 32'(se));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        pulses("rst", 4'b0000, 1'b0, 1'b0);
        check("rst.data", out_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(1, 1, 8'h10); pulses("t1.s0", 4'b0001, 0, 0);
        send(1, 0, 8'h11); pulses("t1.s1", 4'b0010, 0, 0);
        send(1, 0, 8'h12); pulses("t1.s2", 4'b0100, 0, 0);
        send(1, 0, 8'h13); pulses("t1.s3", 4'b1000, 1, 0);
        check("t1.data", out_data, 32'h13121110);
        send(0, 0, 8'hFF); pulses("t1.idle", 4'b0000, 0, 0);
        check("t1.hold", out_data, 32'h13121110);

        for (int k = 0; k < 4; k++) begin
            send(1, k == 0, 8'(8'h20 + k));
            pulses("t2.s", 4'(1 << k), k == 3, 0);
            send(0, 1, 8'hEE); pulses("t2.gap1", 4'b0000, 0, 0);
            send(0, 0, 8'hEE); pulses("t2.gap2", 4'b0000, 0, 0);
        end
        check("t2.data", out_data, 32'h23222120);

        send(1, 1, 8'h30); pulses("t3.s0", 4'b0001, 0, 0);
        send(1, 0, 8'h31); pulses("t3.s1", 4'b0010, 0, 0);
        send(1, 1, 8'hAA); pulses("t3.early", 4'b0001, 0, 1);
        check("t3.slot0", out_data, 32'h2322_31AA);
        send(1, 0, 8'h32); pulses("t3.r1", 4'b0010, 0, 0);
        send(1, 0, 8'h33); pulses("t3.r2", 4'b0100, 0, 0);
        send(1, 0, 8'h34); pulses("t3.r3", 4'b1000, 1, 0);
        check("t3.data", out_data, 32'h343332AA);

        send(1, 0, 8'h55); pulses("t4.miss", 4'b0000, 0, 1);
        check("t4.data", out_data, 32'h343332AA);
        send(1, 0, 8'h56); pulses("t4.hunt1", 4'b0000, 0, 0);
        send(1, 0, 8'h57); pulses("t4.hunt2", 4'b0000, 0, 0);
        check("t4.hold", out_data, 32'h343332AA);
        send(1, 1, 8'h40); pulses("t4.relock", 4'b0001, 0, 0);
        send(1, 0, 8'h41); pulses("t4.ch1", 4'b0010, 0, 0);
        check("t4.data2", out_data, 32'h34334140);
`ifdef TDM_DEMUX_ERRCNT_EN
        check("t6.cnt2", 32'(err_count), 32'd2);
`endif

        #2;
        rst_n = 1'b0;
        #1;
        check("t5.data", out_data, 32'h0);
        pulses("t5.async", 4'b0000, 0, 0);
`ifdef TDM_DEMUX_ERRCNT_EN
        check("t5.cnt", 32'(err_count), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        send(1, 0, 8'h60); pulses("t5.drop", 4'b0000, 0, 0);
        send(1, 1, 8'h61); pulses("t5.lock", 4'b0001, 0, 0);
        check("t5.data2", out_data, 32'h00000061);

`ifdef TDM_DEMUX_ERRCNT_EN
        send(1, 1, 8'h70); pulses("t6.first", 4'b0001, 0, 1);
        check("t6.cnt1", 32'(err_count), 32'd1);
        for (int k = 1; k < 260; k++) send(1, 1, 8'(k));
        check("t6.err", 32'(sync_err), 32'd1);
        check("t6.sat", 32'(err_count), 32'd255);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
